// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared encodings and defaults for the flash access arbiter
package flash_pkg;

   typedef enum logic [1:0] {
      FLASH_OP_READ   = 2'b00,
      FLASH_OP_WRITE  = 2'b01,
      FLASH_OP_ERASE0 = 2'b10,
      FLASH_OP_ERASE1 = 2'b11
   } flash_op_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } flash_state_e;

   localparam int FLASH_PRESCALE      = 5;
   localparam int FLASH_STARVE_LIMIT  = 4;
   localparam int FLASH_TIMEOUT_TICKS = 4096;

   function automatic logic op_is_read(input flash_op_e op);
      return op == FLASH_OP_READ;
   endfunction

endpackage

// File: rtl/flash_access_arbiter_if.sv
// rtl/flash_access_arbiter_if.sv - requester and low-level controller signals of the arbiter
interface flash_access_arbiter_if;

   logic        i_fetch_valid;
   logic [23:0] i_fetch_addr;
   logic        o_fetch_ready;
   logic        o_fetch_rvalid;
   logic [31:0] o_fetch_rdata;
   logic        o_fetch_err;

   logic        i_data_valid;
   logic [1:0]  i_data_op;
   logic [23:0] i_data_addr;
   logic [31:0] i_data_wdata;
   logic        o_data_ready;
   logic        o_data_rvalid;
   logic [31:0] o_data_rdata;
   logic        o_data_bvalid;
   logic        o_data_err;

   logic        o_llc_start;
   logic [23:0] o_llc_address;
   logic [31:0] o_llc_word;
   logic        o_llc_dir;
   logic        o_llc_erase;
   logic [31:0] o_llc_clock_ctr;
   logic [31:0] i_llc_word;
   logic        i_llc_valid;
   logic        i_llc_busy;

   modport slave (
      input  i_fetch_valid, i_fetch_addr,
      output o_fetch_ready, o_fetch_rvalid, o_fetch_rdata, o_fetch_err,
      input  i_data_valid, i_data_op, i_data_addr, i_data_wdata,
      output o_data_ready, o_data_rvalid, o_data_rdata, o_data_bvalid, o_data_err,
      output o_llc_start, o_llc_address, o_llc_word, o_llc_dir, o_llc_erase, o_llc_clock_ctr,
      input  i_llc_word, i_llc_valid, i_llc_busy
   );

   modport master (
      output i_fetch_valid, i_fetch_addr,
      input  o_fetch_ready, o_fetch_rvalid, o_fetch_rdata, o_fetch_err,
      output i_data_valid, i_data_op, i_data_addr, i_data_wdata,
      input  o_data_ready, o_data_rvalid, o_data_rdata, o_data_bvalid, o_data_err,
      input  o_llc_start, o_llc_address, o_llc_word, o_llc_dir, o_llc_erase, o_llc_clock_ctr,
      output i_llc_word, i_llc_valid, i_llc_busy
   );

endinterface

// File: rtl/flash_pace_counter.sv
// rtl/flash_pace_counter.sv - prescale counter pacing command-side decisions to controller ticks
module flash_pace_counter
   import flash_pkg::*;
#(
   parameter int PRESCALE = FLASH_PRESCALE
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        load,
   output logic        tick,
   output logic [31:0] ctr
);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         ctr <= '0;
      end else if (load) begin
         ctr <= 32'(PRESCALE - 1);
      end else if (ctr != '0) begin
         ctr <= ctr - 32'd1;
      end
   end

   assign tick = (ctr == '0);

endmodule

// File: rtl/flash_access_arbiter.sv
// rtl/flash_access_arbiter.sv - shares the QSPI low-level controller between fetch and data ports
module flash_access_arbiter
   import flash_pkg::*;
#(
   parameter int PRESCALE      = FLASH_PRESCALE,
   parameter int STARVE_LIMIT  = FLASH_STARVE_LIMIT,
   parameter int TIMEOUT_TICKS = FLASH_TIMEOUT_TICKS
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   flash_access_arbiter_if.slave bus
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);

   flash_state_e  state;
   flash_op_e     op;
   logic          owner_data;
   logic [SW-1:0] streak;
   logic [TW-1:0] to_cnt;

   logic tick;
   logic pace_load;
   logic grant;
   logic pick_data;
   logic starved;
   logic last_tick;
   logic wait_done;
   logic timed_out;

   always_comb begin
      starved   = (streak == SW'(STARVE_LIMIT));
      grant     = (state == IDLE) && !bus.i_llc_busy && (bus.i_fetch_valid || bus.i_data_valid);
      pick_data = bus.i_data_valid && (!bus.i_fetch_valid || starved);
      last_tick = (to_cnt == TW'(TIMEOUT_TICKS - 1));
      wait_done = (state == WAIT) && tick && (bus.i_llc_valid || last_tick);
      timed_out = !bus.i_llc_valid;
      // The tick that ends WAIT does not reload, so the counter rests at 0 through RESP and IDLE.
      pace_load = grant || (tick && ((state == ISSUE) || ((state == WAIT) && !wait_done)));
   end

   flash_pace_counter #(.PRESCALE(PRESCALE)) u_pace (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .load   (pace_load),
      .tick   (tick),
      .ctr    (bus.o_llc_clock_ctr)
   );

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state              <= IDLE;
         op                 <= FLASH_OP_READ;
         owner_data         <= 1'b0;
         streak             <= '0;
         to_cnt             <= '0;
         bus.o_fetch_ready  <= 1'b0;
         bus.o_fetch_rvalid <= 1'b0;
         bus.o_fetch_rdata  <= '0;
         bus.o_fetch_err    <= 1'b0;
         bus.o_data_ready   <= 1'b0;
         bus.o_data_rvalid  <= 1'b0;
         bus.o_data_rdata   <= '0;
         bus.o_data_bvalid  <= 1'b0;
         bus.o_data_err     <= 1'b0;
         bus.o_llc_start    <= 1'b0;
         bus.o_llc_address  <= '0;
         bus.o_llc_word     <= '0;
         bus.o_llc_dir      <= 1'b0;
         bus.o_llc_erase    <= 1'b0;
      end else begin
         bus.o_fetch_ready  <= 1'b0;
         bus.o_fetch_rvalid <= 1'b0;
         bus.o_fetch_err    <= 1'b0;
         bus.o_data_ready   <= 1'b0;
         bus.o_data_rvalid  <= 1'b0;
         bus.o_data_bvalid  <= 1'b0;
         bus.o_data_err     <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  state           <= ISSUE;
                  bus.o_llc_start <= 1'b1;
                  owner_data      <= pick_data;
                  if (pick_data) begin
                     op                <= flash_op_e'(bus.i_data_op);
                     bus.o_data_ready  <= 1'b1;
                     bus.o_llc_address <= bus.i_data_addr;
                     bus.o_llc_dir     <= bus.i_data_op[0];
                     bus.o_llc_erase   <= bus.i_data_op[1];
                     if (flash_op_e'(bus.i_data_op) == FLASH_OP_WRITE) begin
                        bus.o_llc_word <= bus.i_data_wdata;
                     end
                     streak <= '0;
                  end else begin
                     op                <= FLASH_OP_READ;
                     bus.o_fetch_ready <= 1'b1;
                     bus.o_llc_address <= bus.i_fetch_addr;
                     bus.o_llc_dir     <= 1'b0;
                     bus.o_llc_erase   <= 1'b0;
                     if (bus.i_data_valid && !starved) begin
                        streak <= streak + SW'(1);
                     end
                  end
               end
            end
            ISSUE: begin
               if (tick) begin
                  bus.o_llc_start <= 1'b0;
                  state           <= WAIT;
               end
            end
            WAIT: begin
               if (wait_done) begin
                  state <= RESP;
                  if (owner_data) begin
                     if (op_is_read(op)) begin
                        bus.o_data_rvalid <= 1'b1;
                        bus.o_data_rdata  <= timed_out ? '0 : bus.i_llc_word;
                     end else begin
                        bus.o_data_bvalid <= 1'b1;
                     end
                     bus.o_data_err <= timed_out;
                  end else begin
                     bus.o_fetch_rvalid <= 1'b1;
                     bus.o_fetch_rdata  <= timed_out ? '0 : bus.i_llc_word;
                     bus.o_fetch_err    <= timed_out;
                  end
               end else if (tick) begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            RESP: begin
               bus.o_llc_dir     <= 1'b0;
               bus.o_llc_erase   <= 1'b0;
               bus.o_llc_address <= '0;
               to_cnt            <= '0;
               state             <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_access_arbiter.sv
// tb/tb_flash_access_arbiter.sv - randomized self-checking bench for flash_access_arbiter
module tb_flash_access_arbiter;

   localparam int P     = 5;
   localparam int LIMIT = 4;
   localparam int TMO   = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_word = '0;
   int          resp_c;
   int          grants;
   bit          got;
   bit          order[$];
   int          streak_m;

   flash_access_arbiter_if bus();

   flash_access_arbiter #(
      .PRESCALE      (P),
      .STARVE_LIMIT  (LIMIT),
      .TIMEOUT_TICKS (TMO)
   ) dut (
      .ACLK   (clk),
      .ARESET (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      vectors++;
      if (got_v !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
      end
   endtask

   task automatic idle_inputs();
      bus.i_fetch_valid = 1'b0;
      bus.i_fetch_addr  = '0;
      bus.i_data_valid  = 1'b0;
      bus.i_data_op     = '0;
      bus.i_data_addr   = '0;
      bus.i_data_wdata  = '0;
      bus.i_llc_word    = '0;
      bus.i_llc_valid   = 1'b0;
      bus.i_llc_busy    = 1'b0;
   endtask

   // One command; the controller raises valid d cycles after start rises and holds it until the response.
   task automatic run_cmd(input bit is_data, input logic [1:0] op, input logic [23:0] addr,
                          input logic [31:0] wdata, input int d, input logic [31:0] word);
      int  c;
      int  rc;
      int  starts;
      int  k;
      bit  g;
      bit  noise;
      bus.i_llc_word  = word;
      bus.i_llc_valid = 1'b0;
      if (is_data) begin
         bus.i_data_valid = 1'b1;
         bus.i_data_op    = op;
         bus.i_data_addr  = addr;
         bus.i_data_wdata = wdata;
      end else begin
         bus.i_fetch_valid = 1'b1;
         bus.i_fetch_addr  = addr;
      end
      g = 1'b0;
      for (int i = 0; i < 20 && !g; i++) begin
         @(negedge clk);
         g = is_data ? bus.o_data_ready : bus.o_fetch_ready;
      end
      bus.i_fetch_valid = 1'b0;
      bus.i_data_valid  = 1'b0;
      check_val("grant", g, 1);
      if (!g) return;
      if (is_data && op == 2'b01) exp_word = wdata;
      check_val("start_at_grant", bus.o_llc_start, 1);
      check_val("llc_address", bus.o_llc_address, addr);
      check_val("llc_dir", bus.o_llc_dir, is_data ? op[0] : 1'b0);
      check_val("llc_erase", bus.o_llc_erase, is_data ? op[1] : 1'b0);
      check_val("llc_word", bus.o_llc_word, exp_word);
      k = 1;
      while (P - 1 + P * k < d) k++;
      starts = 1;
      noise  = is_data ? bus.o_fetch_ready : bus.o_data_ready;
      rc     = -1;
      bus.i_llc_valid = (d <= 0);
      for (c = 1; c < 400 && rc < 0; c++) begin
         @(negedge clk);
         if (bus.o_llc_start) starts++;
         if (is_data)
            noise |= bus.o_fetch_ready | bus.o_fetch_rvalid | bus.o_fetch_err;
         else
            noise |= bus.o_data_ready | bus.o_data_rvalid | bus.o_data_bvalid | bus.o_data_err;
         if (is_data ? (bus.o_data_rvalid | bus.o_data_bvalid) : bus.o_fetch_rvalid)
            rc = c;
         else
            bus.i_llc_valid = (c >= d);
      end
      check_val("resp_cycle", rc, P + P * k);
      if (rc > 0) begin
         if (is_data) begin
            check_val("data_rvalid", bus.o_data_rvalid, op == 2'b00);
            check_val("data_bvalid", bus.o_data_bvalid, op != 2'b00);
            check_val("data_err", bus.o_data_err, 0);
            if (op == 2'b00) check_val("data_rdata", bus.o_data_rdata, word);
         end else begin
            check_val("fetch_err", bus.o_fetch_err, 0);
            check_val("fetch_rdata", bus.o_fetch_rdata, word);
         end
      end
      check_val("other_port_silent", noise, 0);
      bus.i_llc_valid = 1'b0;
      @(negedge clk);
      check_val("start_cycles", starts, P);
      check_val("llc_cleared", {bus.o_llc_address, bus.o_llc_dir, bus.o_llc_erase}, 0);
   endtask

   initial begin
      idle_inputs();
      @(negedge clk);
      check_val("rst_llc", {bus.o_llc_start, bus.o_llc_dir, bus.o_llc_erase, bus.o_llc_address}, 0);
      check_val("rst_ctr", bus.o_llc_clock_ctr, 0);
      check_val("rst_word", bus.o_llc_word, 0);
      check_val("rst_pulses", {bus.o_fetch_ready, bus.o_fetch_rvalid, bus.o_fetch_err, bus.o_data_ready,
                               bus.o_data_rvalid, bus.o_data_bvalid, bus.o_data_err}, 0);
      rst = 1'b0;
      @(negedge clk);

      run_cmd(1'b0, 2'b00, 24'h000100, 32'h0, 3 * P, 32'hDEADBEEF);
      run_cmd(1'b1, 2'b01, 24'h001000, 32'h12345678, 2, 32'hA5A5A5A5);
      run_cmd(1'b1, 2'b11, 24'h020000, 32'h0BADF00D, 7, 32'h11111111);
      run_cmd(1'b1, 2'b10, 24'h020000, 32'hCAFEF00D, 12, 32'h22222222);
      run_cmd(1'b1, 2'b00, 24'hFFFFFC, 32'h0, 0, 32'h87654321);

      // A request withdrawn while the controller is busy is never granted.
      bus.i_llc_busy    = 1'b1;
      bus.i_fetch_valid = 1'b1;
      bus.i_fetch_addr  = 24'h000400;
      grants = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         grants += int'(bus.o_fetch_ready | bus.o_data_ready);
      end
      bus.i_fetch_valid = 1'b0;
      bus.i_llc_busy    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         grants += int'(bus.o_fetch_ready | bus.o_data_ready);
      end
      check_val("withdrawn_no_grant", grants, 0);

      for (int n = 0; n < 16; n++) begin
         run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 24'($urandom), $urandom,
                 int'($urandom_range(0, 30)), $urandom);
      end

      // Both ports continuously valid.
      bus.i_fetch_addr  = 24'h000800;
      bus.i_data_op     = 2'b00;
      bus.i_data_addr   = 24'h004000;
      bus.i_llc_word    = 32'h5A5A0000;
      bus.i_llc_valid   = 1'b1;
      bus.i_fetch_valid = 1'b1;
      bus.i_data_valid  = 1'b1;
      for (int i = 0; i < 400 && order.size() < 10; i++) begin
         @(negedge clk);
         if (bus.o_fetch_ready | bus.o_data_ready)
            check_val("dual_ready", bus.o_fetch_ready & bus.o_data_ready, 0);
         if (bus.o_fetch_ready) order.push_back(1'b0);
         else if (bus.o_data_ready) order.push_back(1'b1);
      end
      bus.i_fetch_valid = 1'b0;
      bus.i_data_valid  = 1'b0;
      check_val("grant_count", order.size(), 10);
      streak_m = 0;
      for (int i = 0; i < 10 && i < order.size(); i++) begin
         if (streak_m == LIMIT) begin
            check_val("grant_order", order[i], 1);
            streak_m = 0;
         end else begin
            check_val("grant_order", order[i], 0);
            streak_m++;
         end
      end
      repeat (20) @(negedge clk);
      bus.i_llc_valid = 1'b0;
      @(negedge clk);

      // Controller never completes.
      bus.i_data_valid = 1'b1;
      bus.i_data_op    = 2'b00;
      bus.i_data_addr  = 24'h0ABCDE;
      bus.i_llc_word   = 32'hFFFFFFFF;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = bus.o_data_ready;
      end
      bus.i_data_valid = 1'b0;
      check_val("to_grant", got, 1);
      resp_c = -1;
      for (int c = 1; c < 21000 && resp_c < 0; c++) begin
         @(negedge clk);
         if (bus.o_data_rvalid | bus.o_data_bvalid) begin
            resp_c = c;
            bus.i_llc_busy    = 1'b1;
            bus.i_fetch_valid = 1'b1;
            bus.i_fetch_addr  = 24'h000200;
         end
      end
      check_val("to_cycle", resp_c, P + P * TMO);
      check_val("to_rvalid", bus.o_data_rvalid, 1);
      check_val("to_err", bus.o_data_err, 1);
      check_val("to_rdata", bus.o_data_rdata, 0);
      bus.i_llc_busy    = 1'b1;
      bus.i_fetch_valid = 1'b1;
      grants = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         grants += int'(bus.o_fetch_ready | bus.o_data_ready);
      end
      check_val("busy_blocks_grant", grants, 0);
      bus.i_llc_busy = 1'b0;
      @(negedge clk);
      check_val("grant_after_busy", bus.o_fetch_ready, 1);
      bus.i_fetch_valid = 1'b0;
      bus.i_llc_word    = 32'h13572468;
      bus.i_llc_valid   = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = bus.o_fetch_rvalid;
      end
      check_val("post_busy_rvalid", got, 1);
      check_val("post_busy_rdata", bus.o_fetch_rdata, 32'h13572468);
      bus.i_llc_valid = 1'b0;
      @(negedge clk);

      // Reset while a fetch read sits in WAIT.
      bus.i_fetch_valid = 1'b1;
      bus.i_fetch_addr  = 24'h000300;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = bus.o_fetch_ready;
      end
      bus.i_fetch_valid = 1'b0;
      check_val("rst_cmd_grant", got, 1);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("async_start", bus.o_llc_start, 0);
      check_val("async_ctr", bus.o_llc_clock_ctr, 0);
      check_val("async_addr", bus.o_llc_address, 0);
      check_val("async_word", bus.o_llc_word, 0);
      exp_word = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus.i_llc_valid = 1'b1;
      grants = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         grants += int'(bus.o_fetch_rvalid | bus.o_fetch_ready | bus.o_llc_start);
      end
      check_val("no_resp_after_rst", grants, 0);
      bus.i_llc_valid = 1'b0;
      run_cmd(1'b0, 2'b00, 24'h000300, 32'h0, 4, 32'h0F0F0F0F);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
